// File: rtl/jk_cmd_if.sv
// Command handshake between a controller and the JK command sequencer.
// The controller presents op/count with valid; the sequencer answers with ready.
interface jk_cmd_if #(
  parameter int CNT_W = 4
) ();
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;

  modport master (output valid, output op, output count, input ready);
  modport slave  (input valid, input op, input count, output ready);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Drives J/K of a downstream JK flip-flop for a commanded number of edges,
// tracks the expected Q in a shadow model and flags any fed-back Q mismatch.
module jk_cmd_sequencer #(
  parameter int CNT_W    = 4,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic     i_clk,
  input  logic     i_reset,
  jk_cmd_if.slave  cmd,
  input  logic     i_clear_err,
  output logic     o_j,
  output logic     o_k,
  input  logic     i_q,
  output logic     o_exp_q,
  output logic     o_busy,
  output logic     o_done,
  output logic     o_mismatch
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_op, w_op_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_first, w_first_nxt;
  logic             r_j, w_j_nxt;
  logic             r_k, w_k_nxt;
  logic             r_exp_q, w_exp_q_nxt;
  logic             r_done, w_done_nxt;
  logic             r_mismatch, w_mismatch_nxt;
  logic             w_cmp_fail;

  // Q the flip-flop will hold after one edge of the given op.
  function automatic logic jk_next_q(input logic [1:0] op, input logic q);
    logic nq;
    case (op)
      2'b00:   nq = q;
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      2'b11:   nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_op       <= 2'b00;
      r_cnt      <= {CNT_W{1'b0}};
      r_first    <= 1'b0;
      r_j        <= 1'b0;
      r_k        <= 1'b0;
      r_exp_q    <= 1'b0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_cnt      <= w_cnt_nxt;
      r_first    <= w_first_nxt;
      r_j        <= w_j_nxt;
      r_k        <= w_k_nxt;
      r_exp_q    <= w_exp_q_nxt;
      r_done     <= w_done_nxt;
      r_mismatch <= w_mismatch_nxt;
    end
  end

  // Next-state, J/K drive, shadow model and check-point comparison.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = r_first;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    w_exp_q_nxt = r_exp_q;
    w_done_nxt  = 1'b0;
    w_cmp_fail  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_j_nxt = 1'b0;
        w_k_nxt = 1'b0;
        if (cmd.valid) begin
          w_op_nxt    = cmd.op;
          w_cnt_nxt   = (cmd.count == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : cmd.count;
          w_j_nxt     = cmd.op[1];
          w_k_nxt     = cmd.op[0];
          w_first_nxt = 1'b1;
          w_state_nxt = ST_DRIVE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        // The first edge is where the flip-flop first sees the op, so Q is not yet comparable.
        w_cmp_fail  = ~r_first & (i_q != r_exp_q);
        w_exp_q_nxt = jk_next_q(r_op, r_exp_q);
        w_cnt_nxt   = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        w_first_nxt = 1'b0;
        if (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          w_j_nxt     = 1'b0;
          w_k_nxt     = 1'b0;
          w_state_nxt = ST_SETTLE;
        end else begin
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_SETTLE: begin
        w_cmp_fail  = (i_q != r_exp_q);
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_j_nxt     = 1'b0;
        w_k_nxt     = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    // A failing compare outranks a simultaneous clear request.
    if (CHECK_EN && w_cmp_fail) begin
      w_mismatch_nxt = 1'b1;
    end else if (i_clear_err) begin
      w_mismatch_nxt = 1'b0;
    end else begin
      w_mismatch_nxt = r_mismatch;
    end
  end

  assign cmd.ready  = (r_state == ST_IDLE);
  assign o_busy     = (r_state != ST_IDLE);
  assign o_j        = r_j;
  assign o_k        = r_k;
  assign o_exp_q    = r_exp_q;
  assign o_done     = r_done;
  assign o_mismatch = r_mismatch;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with a behavioural JK flip-flop closing the Q loop.
// Observed vector order: {J, K, exp_q, ready, busy, done, mismatch}.
module tb_jk_cmd_sequencer;

  logic clk;
  logic rst;
  logic clear_err;
  logic j, k, exp_q, busy, done, mismatch;
  logic ff_q;
  logic force_en, force_val;
  logic q_in;
  logic [6:0] obs;
  int n_checks;
  int n_pass;

  jk_cmd_if #(.CNT_W(4)) cmd_if ();

  jk_cmd_sequencer #(.CNT_W(4), .CHECK_EN(1'b1)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .cmd         (cmd_if),
    .i_clear_err (clear_err),
    .o_j         (j),
    .o_k         (k),
    .i_q         (q_in),
    .o_exp_q     (exp_q),
    .o_busy      (busy),
    .o_done      (done),
    .o_mismatch  (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference JK flip-flop sharing clock and reset with the sequencer.
  always @(posedge clk) begin
    if (rst) ff_q <= 1'b0;
    else begin
      case ({j, k})
        2'b00:   ff_q <= ff_q;
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        default: ff_q <= ~ff_q;
      endcase
    end
  end

  assign q_in = force_en ? force_val : ff_q;
  assign obs  = {j, k, exp_q, cmd_if.ready, busy, done, mismatch};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, output bit ok);
    ok = 1'b0;
    cmd_if.valid = 1'b1;
    cmd_if.op    = op;
    cmd_if.count = cnt;
    tick();
    cmd_if.valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs !== 7'b0001000) $display("FAIL reset_state: got %b expected %b", obs, 7'b0001000);
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== 7'b0001000) $display("FAIL reset_idle: got %b expected %b", obs, 7'b0001000);
    else n_pass++;
  endtask

  task automatic test_set();
    cmd_if.valid = 1'b1; cmd_if.op = 2'b10; cmd_if.count = 4'd1;
    tick();
    cmd_if.valid = 1'b0;
    n_checks++;
    if (obs !== 7'b1000100) $display("FAIL set_accept: got %b expected %b", obs, 7'b1000100);
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== 7'b0010100) $display("FAIL set_settle: got %b expected %b", obs, 7'b0010100);
    else n_pass++;
    tick();
    n_checks++;
    if ({obs, q_in} !== 8'b00110101) $display("FAIL set_done: got %b expected %b", {obs, q_in}, 8'b00110101);
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== 7'b0011000) $display("FAIL set_done_pulse_width: got %b expected %b", obs, 7'b0011000);
    else n_pass++;
  endtask

  task automatic test_toggle();
    logic [6:0] expv [5];
    expv[0] = 7'b1110100; expv[1] = 7'b1100100; expv[2] = 7'b1110100;
    expv[3] = 7'b0000100; expv[4] = 7'b0001010;
    cmd_if.valid = 1'b1; cmd_if.op = 2'b11; cmd_if.count = 4'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      cmd_if.valid = 1'b0;
      n_checks++;
      if (obs !== expv[i]) $display("FAIL toggle_cycle%0d: got %b expected %b", i, obs, expv[i]);
      else n_pass++;
    end
    n_checks++;
    if (q_in !== 1'b0) $display("FAIL toggle_final_q: got %b expected %b", q_in, 1'b0);
    else n_pass++;
  endtask

  task automatic test_count_zero();
    bit ok;
    run_cmd(2'b10, 4'd1, ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL zero_precondition_timeout: got %b expected %b", ok, 1'b1);
    else n_pass++;
    cmd_if.valid = 1'b1; cmd_if.op = 2'b01; cmd_if.count = 4'd0;
    tick();
    cmd_if.valid = 1'b0;
    n_checks++;
    if (obs !== 7'b0110100) $display("FAIL zero_accept: got %b expected %b", obs, 7'b0110100);
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== 7'b0000100) $display("FAIL zero_settle: got %b expected %b", obs, 7'b0000100);
    else n_pass++;
    tick();
    n_checks++;
    if ({obs, q_in} !== 8'b00010100) $display("FAIL zero_done: got %b expected %b", {obs, q_in}, 8'b00010100);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    // Forced Q during a one-edge RESET: only the SETTLE compare may flag it.
    force_en = 1'b1; force_val = 1'b1;
    cmd_if.valid = 1'b1; cmd_if.op = 2'b01; cmd_if.count = 4'd1;
    tick();
    cmd_if.valid = 1'b0;
    tick();
    n_checks++;
    if (obs !== 7'b0000100) $display("FAIL mm_first_edge_exempt: got %b expected %b", obs, 7'b0000100);
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== 7'b0001011) $display("FAIL mm_settle_set: got %b expected %b", obs, 7'b0001011);
    else n_pass++;
    force_en = 1'b0;
    tick();
    tick();
    n_checks++;
    if (obs !== 7'b0001001) $display("FAIL mm_sticky: got %b expected %b", obs, 7'b0001001);
    else n_pass++;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_checks++;
    if (obs !== 7'b0001000) $display("FAIL mm_clear: got %b expected %b", obs, 7'b0001000);
    else n_pass++;
    // Mid-DRIVE compare on the second HOLD edge.
    force_en = 1'b1;
    cmd_if.valid = 1'b1; cmd_if.op = 2'b00; cmd_if.count = 4'd2;
    tick();
    cmd_if.valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (obs !== 7'b0000101) $display("FAIL mm_drive_compare: got %b expected %b", obs, 7'b0000101);
    else n_pass++;
    tick();
    clear_err = 1'b1;
    tick();
    n_checks++;
    if (obs !== 7'b0001000) $display("FAIL mm_clear2: got %b expected %b", obs, 7'b0001000);
    else n_pass++;
    // Clear held through a failing SETTLE compare: the set must win.
    cmd_if.valid = 1'b1; cmd_if.op = 2'b01; cmd_if.count = 4'd1;
    tick();
    cmd_if.valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (obs !== 7'b0001011) $display("FAIL mm_set_wins: got %b expected %b", obs, 7'b0001011);
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== 7'b0001000) $display("FAIL mm_clear_after: got %b expected %b", obs, 7'b0001000);
    else n_pass++;
    clear_err = 1'b0;
    force_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    cmd_if.valid = 1'b1; cmd_if.op = 2'b11; cmd_if.count = 4'd5;
    tick();
    cmd_if.valid = 1'b0;
    tick();
    n_checks++;
    if (obs !== 7'b1110100) $display("FAIL rmid_edge1: got %b expected %b", obs, 7'b1110100);
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== 7'b1100100) $display("FAIL rmid_edge2: got %b expected %b", obs, 7'b1100100);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (obs !== 7'b0001000) $display("FAIL rmid_abandon: got %b expected %b", obs, 7'b0001000);
    else n_pass++;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL rmid_no_done: got %b expected %b", saw_done, 1'b0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [6:0] expv [7];
    expv[0] = 7'b0000100; expv[1] = 7'b0000100; expv[2] = 7'b0000100;
    expv[3] = 7'b0001010; expv[4] = 7'b1000100; expv[5] = 7'b0010100;
    expv[6] = 7'b0011010;
    cmd_if.valid = 1'b1; cmd_if.op = 2'b00; cmd_if.count = 4'd2;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) begin
        cmd_if.op = 2'b10; cmd_if.count = 4'd1;
      end
      if (i == 4) cmd_if.valid = 1'b0;
      n_checks++;
      if (obs !== expv[i]) $display("FAIL b2b_cycle%0d: got %b expected %b", i, obs, expv[i]);
      else n_pass++;
    end
    n_checks++;
    if (q_in !== 1'b1) $display("FAIL b2b_final_q: got %b expected %b", q_in, 1'b1);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    clear_err = 1'b0;
    force_en = 1'b0;
    force_val = 1'b0;
    cmd_if.valid = 1'b0;
    cmd_if.op = 2'b00;
    cmd_if.count = 4'd0;
    test_reset();
    test_set();
    test_toggle();
    test_count_zero();
    test_mismatch();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
